cp0_except: RTL and testbench
=============================

Name: cp0_except

Overview:
- Coprocessor-0 register file and exception arbiter, located at the MEM stage boundary.
- Each cycle it combines the MEM-stage instruction's raw exception flags with pending interrupts.
- It produces the 32-bit exception code and EPC for the pipeline controller, which uses them to flush and redirect the PC.
- On commit it updates Status/Cause/EPC/BadVAddr. It also implements mfc0/mtc0 and the Count/Compare timer.

Parameters:
- EXC_W, 8, width of raw exception flag vector.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall_i  in  1  MEM stage stalled this cycle; no exception commits
- mem_valid_i  in  1  MEM stage holds a real instruction
- exc_flags_i  in  8  [0]AdEL-fetch [1]RI [2]Ov [3]Trap [4]Syscall [5]Break [6]AdEL-load [7]AdES
- eret_i  in  1  MEM instruction is eret
- pc_i  in  32  MEM instruction PC
- in_delayslot_i  in  1  MEM instruction is in a delay slot
- bad_addr_i  in  32  data address of the MEM load/store
- int_i  in  6  external hardware interrupts, level
- we_i  in  1  mtc0 write enable
- waddr_i  in  5  mtc0 register number
- wdata_i  in  32  mtc0 data
- raddr_i  in  5  mfc0 register number
- rdata_o  out  32  mfc0 data
- excepttype_o  out  32  exception code to controller (0 = none)
- cp0_epc_o  out  32  EPC to controller
- timer_int_o  out  1  Cause.TI

Behaviour:
- Registers implemented:
  - BadVAddr(8)
  - Count(9)
  - Compare(11)
  - Status(12): bits IM[15:8], EXL[1], IE[0] writable; bit 22 reads 1; others read 0
  - Cause(13): BD[31], TI[30], IP[15:8], ExcCode[6:2]
  - EPC(14)
  - Other numbers read 0; writes to them are ignored.
- Reset: all registers 0 except Status = 0x00400000. Outputs follow from the registers: excepttype_o = 0, cp0_epc_o = 0, timer_int_o = 0.
- Count increments by 1 every second cycle via an internal toggle (toggle reset 0). mtc0 Count loads the value and takes priority over the increment.
- When Count == Compare and Compare != 0, TI sets the next cycle. mtc0 Compare clears TI.
- Cause.IP[7:2] are registered each cycle as {int_i[5] | TI, int_i[4:0]}. IP[1:0] are writable by mtc0 Cause; no other Cause bits are writable.
- Interrupt pending = IE & ~EXL & |(IP & IM), evaluated on the registered values.
- excepttype_o is combinational. It is 0 if !mem_valid_i; otherwise it is the first match, in this priority order:
  - interrupt → 0x01
  - AdEL-fetch → 0x04
  - RI → 0x0a
  - Ov → 0x0c
  - Trap → 0x0d
  - Syscall → 0x08
  - Break → 0x09
  - AdEL-load → 0x04
  - AdES → 0x05
  - eret → 0x0e
  - none → 0
- Commit happens on a clock edge when excepttype_o != 0 and !stall_i:
  - Non-eret exception:
    - If EXL was 0: EPC ← in_delayslot_i ? pc_i-4 : pc_i, and BD ← in_delayslot_i.
    - EXL ← 1.
    - ExcCode ← 0x00 for interrupt, 0x04 for AdEL, 0x05 for AdES, 0x08 for Syscall, 0x09 for Break, 0x0a for RI, 0x0c for Ov, 0x0d for Trap.
    - BadVAddr ← pc_i for AdEL-fetch; BadVAddr ← bad_addr_i for AdEL-load/AdES.
  - eret: EXL ← 0 only.
  - A commit overrides an mtc0 to the same field in the same cycle. An mtc0 to an unaffected field still takes effect.
- Write bypass:
  - rdata_o = (we_i && waddr_i == raddr_i) ? masked wdata_i : register.
  - cp0_epc_o = (we_i && waddr_i == 14) ? wdata_i : EPC.
- stall_i blocks commit and mtc0 writes, but Count and IP keep updating.
- Reset asserted mid-operation: next edge restores the reset values; any in-flight commit is discarded.

Test Plan:
- Reset, then read Status/Count/Cause → 0x00400000/0/0, excepttype_o = 0. After 10 cycles Count = 5.
- Syscall at pc 0xbfc00100, not in a delay slot → excepttype_o = 0x08 same cycle. After the edge: EPC = 0xbfc00100, Cause.ExcCode = 8, Status.EXL = 1.
- AdES with bad_addr 0x80000003, in a delay slot at pc 0xbfc00204 → code 0x05; EPC = 0xbfc00200, BD = 1, BadVAddr = 0x80000003.
- Status = 0x0000ff01, int_i = 6'b000001, RI flag also set → excepttype_o = 0x01 one cycle after int_i rises; ExcCode = 0.
- Compare = 4 → TI sets when Count reaches 4. Then mtc0 Compare → TI = 0.
- EXL = 1 and Break fires → EPC unchanged. Then eret → 0x0e, cp0_epc_o = EPC, EXL cleared. A stalled eret does not clear EXL until stall_i drops.

Source files
------------

// File: rtl/cp0_except.sv
// Coprocessor-0 register file and MEM-stage exception arbiter.
// Produces the exception code and EPC for the pipeline controller, and implements mfc0/mtc0 and the Count/Compare timer.
module cp0_except #(
    parameter int unsigned EXC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             mem_valid_i,
    input  logic [EXC_W-1:0] exc_flags_i,
    input  logic             eret_i,
    input  logic [31:0]      pc_i,
    input  logic             in_delayslot_i,
    input  logic [31:0]      bad_addr_i,
    input  logic [5:0]       int_i,
    input  logic             we_i,
    input  logic [4:0]       waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [4:0]       raddr_i,
    output logic [31:0]      rdata_o,
    output logic [31:0]      excepttype_o,
    output logic [31:0]      cp0_epc_o,
    output logic             timer_int_o
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [31:0] CODE_INT  = 32'h01;
    localparam logic [31:0] CODE_ERET = 32'h0e;

    logic [31:0] badvaddr, count, compare, epc;
    logic [7:0]  status_im;
    logic        status_exl, status_ie;
    logic        cause_bd, cause_ti;
    logic [7:0]  cause_ip;
    logic [4:0]  cause_exccode;
    logic        toggle;

    logic        int_pend, wr_en, commit, sel_fetch, sel_data;
    logic [31:0] status_rd, cause_rd, reg_rd, wr_masked;

    assign int_pend  = status_ie & ~status_exl & (|(cause_ip & status_im));
    assign wr_en     = we_i & ~stall_i;
    assign commit    = (excepttype_o != 32'd0) & ~stall_i;
    assign sel_fetch = mem_valid_i & ~int_pend & exc_flags_i[0];
    assign sel_data  = mem_valid_i & ~int_pend & ~(|exc_flags_i[5:0]) & (exc_flags_i[6] | exc_flags_i[7]);

    assign status_rd = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
    assign cause_rd  = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exccode, 2'b00};

    // Priority arbiter: interrupts first, then instruction exceptions in pipeline order
    always_comb begin
        excepttype_o = 32'd0;
        if (mem_valid_i) begin
            if (int_pend)                excepttype_o = CODE_INT;
            else if (exc_flags_i[0])     excepttype_o = 32'h04;
            else if (exc_flags_i[1])     excepttype_o = 32'h0a;
            else if (exc_flags_i[2])     excepttype_o = 32'h0c;
            else if (exc_flags_i[3])     excepttype_o = 32'h0d;
            else if (exc_flags_i[4])     excepttype_o = 32'h08;
            else if (exc_flags_i[5])     excepttype_o = 32'h09;
            else if (exc_flags_i[6])     excepttype_o = 32'h04;
            else if (exc_flags_i[7])     excepttype_o = 32'h05;
            else if (eret_i)             excepttype_o = CODE_ERET;
        end
    end

    // Register read mux and the value a same-cycle mtc0 would make visible
    always_comb begin
        reg_rd = 32'd0;
        case (raddr_i)
            REG_BADVADDR: reg_rd = badvaddr;
            REG_COUNT:    reg_rd = count;
            REG_COMPARE:  reg_rd = compare;
            REG_STATUS:   reg_rd = status_rd;
            REG_CAUSE:    reg_rd = cause_rd;
            REG_EPC:      reg_rd = epc;
            default:      reg_rd = 32'd0;
        endcase
        wr_masked = 32'd0;
        case (waddr_i)
            REG_BADVADDR, REG_COUNT, REG_COMPARE, REG_EPC: wr_masked = wdata_i;
            REG_STATUS: wr_masked = {9'd0, 1'b1, 6'd0, wdata_i[15:8], 6'd0, wdata_i[1:0]};
            REG_CAUSE:  wr_masked = {cause_rd[31:10], wdata_i[9:8], cause_rd[7:0]};
            default:    wr_masked = 32'd0;
        endcase
    end

    assign rdata_o     = (we_i && waddr_i == raddr_i) ? wr_masked : reg_rd;
    assign cp0_epc_o   = (we_i && waddr_i == REG_EPC) ? wdata_i : epc;
    assign timer_int_o = cause_ti;

    // State update: timer and interrupt sampling, then mtc0, then commit (commit wins on shared fields)
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr      <= 32'd0;
            count         <= 32'd0;
            compare       <= 32'd0;
            epc           <= 32'd0;
            status_im     <= 8'd0;
            status_exl    <= 1'b0;
            status_ie     <= 1'b0;
            cause_bd      <= 1'b0;
            cause_ti      <= 1'b0;
            cause_ip      <= 8'd0;
            cause_exccode <= 5'd0;
            toggle        <= 1'b0;
        end else begin
            toggle <= ~toggle;
            if (wr_en && waddr_i == REG_COUNT)  count <= wdata_i;
            else if (toggle)                     count <= count + 32'd1;

            if (wr_en && waddr_i == REG_COMPARE) begin
                compare  <= wdata_i;
                cause_ti <= 1'b0;
            end else if (count == compare && compare != 32'd0) begin
                cause_ti <= 1'b1;
            end

            cause_ip[7:2] <= {int_i[5] | cause_ti, int_i[4:0]};

            if (wr_en) begin
                case (waddr_i)
                    REG_BADVADDR: badvaddr <= wdata_i;
                    REG_STATUS: begin
                        status_im  <= wdata_i[15:8];
                        status_exl <= wdata_i[1];
                        status_ie  <= wdata_i[0];
                    end
                    REG_CAUSE: cause_ip[1:0] <= wdata_i[9:8];
                    REG_EPC:   epc <= wdata_i;
                    default: ;
                endcase
            end

            if (commit) begin
                if (excepttype_o == CODE_ERET) begin
                    status_exl <= 1'b0;
                end else begin
                    if (!status_exl) begin
                        epc      <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
                        cause_bd <= in_delayslot_i;
                    end
                    status_exl    <= 1'b1;
                    cause_exccode <= (excepttype_o == CODE_INT) ? 5'd0 : excepttype_o[4:0];
                    if (sel_fetch)     badvaddr <= pc_i;
                    else if (sel_data) badvaddr <= bad_addr_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_cp0_except.sv
// Directed bench for cp0_except: stimulus queues expected outputs, a negedge monitor checks them.
module tb_cp0_except;
    logic        clk = 1'b0;
    logic        rst, stall_i, mem_valid_i, eret_i, in_delayslot_i, we_i;
    logic [7:0]  exc_flags_i;
    logic [31:0] pc_i, bad_addr_i, wdata_i;
    logic [5:0]  int_i;
    logic [4:0]  waddr_i, raddr_i;
    logic [31:0] rdata_o, excepttype_o, cp0_epc_o;
    logic        timer_int_o;

    cp0_except #(.EXC_W(8)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .mem_valid_i(mem_valid_i),
        .exc_flags_i(exc_flags_i), .eret_i(eret_i), .pc_i(pc_i),
        .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i), .int_i(int_i),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .raddr_i(raddr_i),
        .rdata_o(rdata_o), .excepttype_o(excepttype_o), .cp0_epc_o(cp0_epc_o),
        .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;    // 0 rdata, 1 excepttype, 2 epc, 3 timer
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: drain every expectation queued for this cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = sbq.pop_front();
                case (e.sel)
                    0:       act = rdata_o;
                    1:       act = excepttype_o;
                    2:       act = cp0_epc_o;
                    default: act = {31'd0, timer_int_o};
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_v(input string n, input int s, input logic [31:0] e);
        exp_t x;
        x.name = n; x.sel = s; x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i = 0; mem_valid_i = 0; exc_flags_i = 8'd0; eret_i = 0;
        in_delayslot_i = 0; bad_addr_i = 32'd0; we_i = 0; waddr_i = 5'd0;
        wdata_i = 32'd0;
    endtask

    task automatic rd(input string n, input logic [4:0] a, input logic [31:0] e);
        raddr_i = a;
        expect_v(n, 0, e);
        tick();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1; waddr_i = a; wdata_i = d;
        tick();
        we_i = 0;
    endtask

    task automatic exc(input string n, input logic [7:0] f, input logic er, input logic [31:0] pc,
                       input logic ds, input logic [31:0] ba, input logic [31:0] code,
                       input logic [31:0] epc_now);
        mem_valid_i = 1; exc_flags_i = f; eret_i = er; pc_i = pc;
        in_delayslot_i = ds; bad_addr_i = ba;
        expect_v(n, 1, code);
        expect_v({n, "_epc"}, 2, epc_now);
        tick();
        mem_valid_i = 0; exc_flags_i = 8'd0; eret_i = 0; in_delayslot_i = 0;
    endtask

    initial begin
        idle();
        rst = 1; int_i = 6'd0; pc_i = 32'd0; raddr_i = 5'd0;
        tick(); tick();
        rst = 0;

        // Reset values; Count advances once every two edges
        expect_v("reset_exc", 1, 32'd0);
        expect_v("reset_epc", 2, 32'd0);
        expect_v("reset_ti", 3, 32'd0);
        rd("reset_count", 5'd9, 32'd0);
        rd("reset_status", 5'd12, 32'h0040_0000);
        rd("reset_cause", 5'd13, 32'd0);
        repeat (7) tick();
        rd("count_after_10", 5'd9, 32'd5);

        // Syscall, not in a delay slot
        exc("syscall", 8'h10, 0, 32'hbfc0_0100, 0, 32'd0, 32'h08, 32'd0);
        rd("sys_epc", 5'd14, 32'hbfc0_0100);
        rd("sys_cause", 5'd13, 32'h0000_0020);
        rd("sys_status", 5'd12, 32'h0040_0002);
        exc("eret1", 8'h00, 1, 32'h0, 0, 32'd0, 32'h0e, 32'hbfc0_0100);
        rd("eret1_status", 5'd12, 32'h0040_0000);

        // AdES in a delay slot
        exc("ades", 8'h80, 0, 32'hbfc0_0204, 1, 32'h8000_0003, 32'h05, 32'hbfc0_0100);
        rd("ades_epc", 5'd14, 32'hbfc0_0200);
        rd("ades_cause", 5'd13, 32'h8000_0014);
        rd("ades_badvaddr", 5'd8, 32'h8000_0003);
        exc("eret2", 8'h00, 1, 32'h0, 0, 32'd0, 32'h0e, 32'hbfc0_0200);

        // Interrupt beats RI, one cycle after int_i rises
        we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_ff01; raddr_i = 5'd12;
        expect_v("status_bypass", 0, 32'h0040_ff01);
        tick();
        we_i = 0;
        int_i = 6'b000001;
        expect_v("int_not_yet", 1, 32'd0);
        tick();
        exc("int", 8'h02, 0, 32'hbfc0_0300, 0, 32'd0, 32'h01, 32'hbfc0_0200);
        rd("int_cause", 5'd13, 32'h0000_0400);
        int_i = 6'd0;
        rd("int_epc", 5'd14, 32'hbfc0_0300);
        rd("int_status", 5'd12, 32'h0040_ff03);
        mtc0(5'd12, 32'h0000_0000);

        // Timer: Compare = 4, Count reloaded to 0
        mtc0(5'd11, 32'd4);
        mtc0(5'd9, 32'd0);
        expect_v("ti_low", 3, 32'd0);
        tick();
        repeat (11) tick();
        expect_v("ti_set", 3, 32'd1);
        rd("count_6", 5'd9, 32'd6);
        rd("ti_cause", 5'd13, 32'h4000_8000);
        mtc0(5'd11, 32'h0000_0100);
        expect_v("ti_cleared", 3, 32'd0);

        // EXL already set: Break keeps EPC; stalled eret holds EXL
        mtc0(5'd12, 32'h0000_0002);
        exc("break", 8'h20, 0, 32'hbfc0_0400, 0, 32'd0, 32'h09, 32'hbfc0_0300);
        rd("break_epc", 5'd14, 32'hbfc0_0300);
        rd("break_cause", 5'd13, 32'h0000_0024);
        stall_i = 1;
        exc("eret_stall", 8'h00, 1, 32'h0, 0, 32'd0, 32'h0e, 32'hbfc0_0300);
        stall_i = 0;
        rd("stall_status", 5'd12, 32'h0040_0002);
        exc("eret3", 8'h00, 1, 32'h0, 0, 32'd0, 32'h0e, 32'hbfc0_0300);
        rd("eret3_status", 5'd12, 32'h0040_0000);

        // Reset during a committing exception discards it
        rst = 1;
        exc("rst_sys", 8'h10, 0, 32'hbfc0_0500, 0, 32'd0, 32'h08, 32'hbfc0_0300);
        rst = 0;
        expect_v("rst_epc_o", 2, 32'd0);
        rd("rst_status", 5'd12, 32'h0040_0000);
        rd("rst_cause", 5'd13, 32'd0);

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
